mem_rd_agent: RTL and testbench
===============================

MEM_RD_AGENT -- requirements
Module: mem_rd_agent

Interface
REQ-001 Parameter DATA_WIDTH, default 64: AXI read data width in bits; 64 or 128 only.
REQ-002 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 Parameter OUTSTANDING_MAX, default 16: maximum bursts in flight, 1..255.
REQ-004 Parameter BURST_LEN, default 16: beats per burst, 1..256.
REQ-005 Parameter ADDR_BASE, default 32'h4000_0000: first burst address; aligned to the burst byte size.
REQ-006 Parameter ADDR_HIGH, default 32'h5000_0000: exclusive upper bound of the address window.
REQ-007 Parameter CNT_BITS, default 32: width of the burst-count and debug counters.
REQ-008 Ports, in order: clk in 1 clock; rst_n in 1 reset; start in 1 run request; num_bursts in CNT_BITS bursts per run; busy out 1; done out 1 one-cycle completion pulse.
REQ-009 AR ports: m_axi_araddr out ADDR_WIDTH; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-010 R ports: m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1.
REQ-011 FIFO write ports: fifo_wrreq out 1; fifo_wdata out DATA_WIDTH; fifo_full in 1.
REQ-012 Status ports: outstanding out 8 bursts in flight; dbg_beat_cnt out CNT_BITS; dbg_err_cnt out CNT_BITS.
REQ-013 One clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE -> RUN on start=1; start is ignored in every state except IDLE.
REQ-016 RUN: issue AR bursts until issued == num_bursts, then -> DRAIN.
REQ-017 DRAIN -> DONE when outstanding == 0; DONE -> IDLE after one cycle with done=1.
REQ-018 num_bursts == 0: IDLE -> RUN -> DRAIN -> DONE with no AR issued; done=1 exactly 3 cycles after start.
REQ-019 busy = 1 in RUN, DRAIN and DONE; busy = 0 in IDLE.
REQ-020 Constant outputs: m_axi_arlen = BURST_LEN-1; m_axi_arsize = log2(DATA_WIDTH/8); m_axi_arburst = 2'b01 (INCR).
REQ-021 m_axi_arvalid asserts in RUN only when issued < num_bursts and outstanding < OUTSTANDING_MAX.
REQ-022 Once asserted, m_axi_arvalid and m_axi_araddr hold stable until m_axi_arready=1.
REQ-023 Address starts at ADDR_BASE each run and advances by BURST_LEN*DATA_WIDTH/8 on every AR handshake.
REQ-024 If the advanced address is >= ADDR_HIGH, the address wraps to ADDR_BASE.
REQ-025 outstanding: +1 on an AR handshake; -1 on an R handshake with m_axi_rlast=1; unchanged when both occur in the same cycle.
REQ-026 m_axi_rready = ~fifo_full, combinational.
REQ-027 fifo_wrreq = m_axi_rvalid & m_axi_rready; fifo_wdata = m_axi_rdata, combinational, with zero added latency.
REQ-028 R beats arriving in IDLE are still forwarded to the FIFO and still decrement outstanding.

Reset
REQ-029 rst_n=0 at a clk edge forces: state IDLE, busy/done/arvalid 0, araddr ADDR_BASE, outstanding 0, issued count 0, debug counters 0.
REQ-030 Reset mid-run abandons in-flight bursts without waiting; m_axi_arvalid is 0 in the first cycle after reset.

Configuration
REQ-031 Macro MEM_RD_AGENT_DEBUG_EN defined: dbg_beat_cnt +1 per R handshake; dbg_err_cnt +1 per R handshake with m_axi_rresp != 0.
REQ-032 With MEM_RD_AGENT_DEBUG_EN defined, both counters wrap at 2^CNT_BITS and clear on reset only, not on start.
REQ-033 MEM_RD_AGENT_DEBUG_EN undefined: dbg_beat_cnt and dbg_err_cnt tie to 0 and no counter registers exist.

Verification
REQ-034 Defaults, num_bursts=4, arready=1, immediate 16-beat R per burst, fifo_full=0 -> araddr 0x4000_0000, 0x4000_0080, 0x4000_0100, 0x4000_0180; 64 fifo_wrreq; one done pulse.
REQ-035 OUTSTANDING_MAX=2, num_bursts=5, R withheld -> exactly 2 AR handshakes, outstanding=2, arvalid=0; releasing R completes all 5 bursts, then done.
REQ-036 ADDR_HIGH=ADDR_BASE+0x100, num_bursts=3 -> araddr 0x4000_0000, 0x4000_0080, 0x4000_0000.
REQ-037 arready=0 for 5 cycles -> arvalid and araddr held stable throughout; fifo_full=1 -> rready=0 and no wrreq.
REQ-038 Same-cycle AR handshake and R-last handshake -> outstanding unchanged; rst_n=0 mid-run -> all outputs at reset values next cycle.
REQ-039 Macro defined, 2 beats with rresp=2'b10 among 32 -> dbg_beat_cnt=32, dbg_err_cnt=2; macro undefined -> both read 0.

Source files
------------

// File: rtl/mem_rd_agent.sv
// AXI read agent: issues fixed-length INCR bursts over an address window and streams R beats into a FIFO.
// Define MEM_RD_AGENT_DEBUG_EN to build the R-beat and R-error debug counters.
module mem_rd_agent #(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    OUTSTANDING_MAX = 16,
    parameter int                    BURST_LEN       = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH       = 32'h5000_0000,
    parameter int                    CNT_BITS        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_BITS-1:0]   num_bursts,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  fifo_wrreq,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_full,
    output logic [7:0]            outstanding,
    output logic [CNT_BITS-1:0]   dbg_beat_cnt,
    output logic [CNT_BITS-1:0]   dbg_err_cnt
);

    localparam int                  BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] STEP        = (ADDR_WIDTH+1)'(BURST_BYTES);
    localparam logic [7:0]          OUT_MAX     = 8'(OUTSTANDING_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] issued, num_lat;
    logic                ar_hs, r_hs, rlast_hs;
    logic [ADDR_WIDTH:0] addr_inc;

    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;

    assign m_axi_rready = ~fifo_full;
    assign fifo_wrreq   = m_axi_rvalid & m_axi_rready;
    assign fifo_wdata   = m_axi_rdata;

    assign ar_hs    = m_axi_arvalid & m_axi_arready;
    assign r_hs     = m_axi_rvalid & m_axi_rready;
    assign rlast_hs = r_hs & m_axi_rlast;
    // One extra bit so the window compare still works when the step carries past the top of the address space.
    assign addr_inc = {1'b0, m_axi_araddr} + STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issued == num_lat) state_nxt = DRAIN;
            DRAIN:   if (outstanding == 8'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // arvalid only drops on its own handshake: issued and outstanding cannot move it otherwise.
    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        m_axi_arvalid = (state == RUN) && (issued < num_lat) && (outstanding < OUT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axi_araddr <= ADDR_BASE;
            issued       <= '0;
            num_lat      <= '0;
        end else if (state == IDLE && start) begin
            m_axi_araddr <= ADDR_BASE;
            issued       <= '0;
            num_lat      <= num_bursts;
        end else if (ar_hs) begin
            issued       <= issued + 1'b1;
            m_axi_araddr <= (addr_inc >= {1'b0, ADDR_HIGH}) ? ADDR_BASE : addr_inc[ADDR_WIDTH-1:0];
        end
    end

    // R beats keep draining outstanding even in IDLE; never underflow on a stray rlast.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= 8'd0;
        end else begin
            case ({ar_hs, rlast_hs})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef MEM_RD_AGENT_DEBUG_EN
    logic [CNT_BITS-1:0] beat_q, err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q <= '0;
            err_q  <= '0;
        end else if (r_hs) begin
            beat_q <= beat_q + 1'b1;
            if (m_axi_rresp != 2'b00) err_q <= err_q + 1'b1;
        end
    end

    assign dbg_beat_cnt = beat_q;
    assign dbg_err_cnt  = err_q;
`else
    logic dbg_unused;

    assign dbg_unused   = ^m_axi_rresp;
    assign dbg_beat_cnt = '0;
    assign dbg_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_rd_agent.sv
// Directed bench for mem_rd_agent: default instance plus one with OUTSTANDING_MAX=2 and a 0x100-byte window.
`timescale 1ns/1ps
module tb_mem_rd_agent;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        start, arready, rlast, rvalid, full;
    logic [1:0][31:0]  num;
    logic [1:0][63:0]  rdata;
    logic [1:0][1:0]   rresp;
    wire  [1:0]        busy, done, arvalid, rready, wrreq;
    wire  [1:0][31:0]  araddr, beat_cnt, err_cnt;
    wire  [1:0][7:0]   arlen, outstanding;
    wire  [1:0][2:0]   arsize;
    wire  [1:0][1:0]   arburst;
    wire  [1:0][63:0]  wdata;

    mem_rd_agent u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .num_bursts(num[0]), .busy(busy[0]), .done(done[0]),
        .m_axi_araddr(araddr[0]), .m_axi_arlen(arlen[0]), .m_axi_arsize(arsize[0]), .m_axi_arburst(arburst[0]),
        .m_axi_arvalid(arvalid[0]), .m_axi_arready(arready[0]), .m_axi_rdata(rdata[0]), .m_axi_rresp(rresp[0]),
        .m_axi_rlast(rlast[0]), .m_axi_rvalid(rvalid[0]), .m_axi_rready(rready[0]), .fifo_wrreq(wrreq[0]),
        .fifo_wdata(wdata[0]), .fifo_full(full[0]), .outstanding(outstanding[0]),
        .dbg_beat_cnt(beat_cnt[0]), .dbg_err_cnt(err_cnt[0])
    );

    mem_rd_agent #(.OUTSTANDING_MAX(2), .ADDR_HIGH(32'h4000_0100)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .num_bursts(num[1]), .busy(busy[1]), .done(done[1]),
        .m_axi_araddr(araddr[1]), .m_axi_arlen(arlen[1]), .m_axi_arsize(arsize[1]), .m_axi_arburst(arburst[1]),
        .m_axi_arvalid(arvalid[1]), .m_axi_arready(arready[1]), .m_axi_rdata(rdata[1]), .m_axi_rresp(rresp[1]),
        .m_axi_rlast(rlast[1]), .m_axi_rvalid(rvalid[1]), .m_axi_rready(rready[1]), .fifo_wrreq(wrreq[1]),
        .fifo_wdata(wdata[1]), .fifo_full(full[1]), .outstanding(outstanding[1]),
        .dbg_beat_cnt(beat_cnt[1]), .dbg_err_cnt(err_cnt[1])
    );

`ifdef MEM_RD_AGENT_DEBUG_EN
    localparam logic [31:0] EXP_BEATS = 32'd32;
    localparam logic [31:0] EXP_ERRS  = 32'd2;
`else
    localparam logic [31:0] EXP_BEATS = 32'd0;
    localparam logic [31:0] EXP_ERRS  = 32'd0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          pend, beat, ar_cnt, wr_cnt, done_cnt;
    bit          both;
    logic [31:0] alog[$];
    logic [63:0] rd_exp;
    bit          ar_m, full_m, hold_r, start_m, err_on;
    logic [31:0] num_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        pend = 0; beat = 0; ar_cnt = 0; wr_cnt = 0; done_cnt = 0;
        alog.delete();
    endtask

    // One cycle: drive after the edge, observe handshakes at the negedge before they commit.
    task automatic cyc(input int d);
        @(posedge clk); #1;
        start[d]   = start_m;
        num[d]     = num_m;
        arready[d] = ar_m;
        full[d]    = full_m;
        rvalid[d]  = !hold_r && (pend > 0);
        rlast[d]   = (beat == 15);
        rd_exp     = {32'h0, 32'hA5A5_0000 + 32'(wr_cnt)};
        rdata[d]   = rd_exp;
        rresp[d]   = (err_on && (wr_cnt == 5 || wr_cnt == 20)) ? 2'b10 : 2'b00;
        @(negedge clk);
        both = 1'b0;
        if (arvalid[d] && arready[d]) begin
            alog.push_back(araddr[d]);
            ar_cnt++;
        end
        if (wrreq[d]) wr_cnt++;
        if (rvalid[d] && rready[d]) begin
            if (rlast[d]) begin
                beat = 0;
                pend--;
                both = arvalid[d] && arready[d];
            end else begin
                beat++;
            end
        end
        if (arvalid[d] && arready[d]) pend++;
        if (done[d]) done_cnt++;
    endtask

    task automatic go(input int d, input int n);
        clr();
        num_m   = 32'(n);
        start_m = 1'b1;
        cyc(d);
        start_m = 1'b0;
    endtask

    task automatic run(input int d, input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            cyc(d);
            n++;
        end
        chk("run_timeout", 64'(n < max), 64'd1);
        repeat (3) cyc(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        start = '0; arready = '0; rlast = '0; rvalid = '0; full = '0;
        num = '0; rdata = '0; rresp = '0;
        ar_m = 1'b1; full_m = 1'b0; hold_r = 1'b0; start_m = 1'b0; err_on = 1'b0; num_m = '0;
        clr();

        // reset state and constant AR fields
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_arvalid", 64'(arvalid[0]), 64'd0);
        chk("rst_araddr", 64'(araddr[0]), 64'(BASE));
        chk("rst_outstanding", 64'(outstanding[0]), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt[0]), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt[0]), 64'd0);
        chk("arlen", 64'(arlen[0]), 64'd15);
        chk("arsize", 64'(arsize[0]), 64'd3);
        chk("arburst", 64'(arburst[0]), 64'd1);
        rst_n = 1'b1;

        // four bursts, immediate R data
        go(0, 4);
        run(0, 300);
        chk("basic_ar_cnt", 64'(ar_cnt), 64'd4);
        chk("basic_addr0", 64'(alog[0]), 64'h4000_0000);
        chk("basic_addr1", 64'(alog[1]), 64'h4000_0080);
        chk("basic_addr2", 64'(alog[2]), 64'h4000_0100);
        chk("basic_addr3", 64'(alog[3]), 64'h4000_0180);
        chk("basic_wrreq", 64'(wr_cnt), 64'd64);
        chk("basic_done", 64'(done_cnt), 64'd1);
        chk("basic_outst", 64'(outstanding[0]), 64'd0);
        chk("basic_busy", 64'(busy[0]), 64'd0);

        // zero bursts: done in the third cycle after start
        go(0, 0);
        cyc(0);
        chk("zero_busy", 64'(busy[0]), 64'd1);
        chk("zero_done_c1", 64'(done[0]), 64'd0);
        cyc(0);
        chk("zero_done_c2", 64'(done[0]), 64'd0);
        cyc(0);
        chk("zero_done_c3", 64'(done[0]), 64'd1);
        cyc(0);
        chk("zero_idle", 64'(busy[0]), 64'd0);
        chk("zero_ar_cnt", 64'(ar_cnt), 64'd0);

        // AR stall holds arvalid/araddr; full FIFO blocks R
        ar_m = 1'b0;
        go(0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0);
            chk("stall_arvalid", 64'(arvalid[0]), 64'd1);
            chk("stall_araddr", 64'(araddr[0]), 64'(BASE));
        end
        ar_m = 1'b1;
        full_m = 1'b1;
        cyc(0);
        for (int i = 0; i < 3; i++) begin
            cyc(0);
            chk("full_rready", 64'(rready[0]), 64'd0);
            chk("full_wrreq", 64'(wrreq[0]), 64'd0);
        end
        full_m = 1'b0;
        cyc(0);
        chk("nofull_wrreq", 64'(wrreq[0]), 64'd1);
        chk("nofull_wdata", wdata[0], rd_exp);
        run(0, 100);
        chk("stall_wr_cnt", 64'(wr_cnt), 64'd16);
        chk("stall_done", 64'(done_cnt), 64'd1);

        // outstanding limit of 2 with R withheld
        hold_r = 1'b1;
        go(1, 5);
        repeat (10) cyc(1);
        chk("lim_ar_cnt", 64'(ar_cnt), 64'd2);
        chk("lim_outst", 64'(outstanding[1]), 64'd2);
        chk("lim_arvalid", 64'(arvalid[1]), 64'd0);
        chk("lim_done_early", 64'(done_cnt), 64'd0);
        hold_r = 1'b0;
        run(1, 400);
        chk("lim_ar_total", 64'(ar_cnt), 64'd5);
        chk("lim_wr_cnt", 64'(wr_cnt), 64'd80);
        chk("lim_done", 64'(done_cnt), 64'd1);
        chk("lim_outst_end", 64'(outstanding[1]), 64'd0);

        // address wrap at ADDR_BASE+0x100
        go(1, 3);
        run(1, 300);
        chk("wrap_ar_cnt", 64'(ar_cnt), 64'd3);
        chk("wrap_addr0", 64'(alog[0]), 64'h4000_0000);
        chk("wrap_addr1", 64'(alog[1]), 64'h4000_0080);
        chk("wrap_addr2", 64'(alog[2]), 64'h4000_0000);

        // AR handshake coincides with R last beat
        go(0, 2);
        for (int i = 0; i < 10 && ar_cnt == 0; i++) cyc(0);
        ar_m = 1'b0;
        for (int i = 0; i < 50 && beat < 15; i++) cyc(0);
        ar_m = 1'b1;
        cyc(0);
        chk("same_both_hs", 64'(both), 64'd1);
        cyc(0);
        chk("same_outst", 64'(outstanding[0]), 64'd1);
        chk("same_ar_cnt", 64'(ar_cnt), 64'd2);

        // reset mid-run
        cyc(0);
        cyc(0);
        rst_n = 1'b0;
        rvalid[0] = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", 64'(busy[0]), 64'd0);
        chk("mrst_done", 64'(done[0]), 64'd0);
        chk("mrst_arvalid", 64'(arvalid[0]), 64'd0);
        chk("mrst_araddr", 64'(araddr[0]), 64'(BASE));
        chk("mrst_outst", 64'(outstanding[0]), 64'd0);
        chk("mrst_beat_cnt", 64'(beat_cnt[0]), 64'd0);
        rst_n = 1'b1;
        clr();
        @(posedge clk); #1;
        chk("post_rst_arvalid", 64'(arvalid[0]), 64'd0);

        // debug counters: two error responses among 32 beats, kept across a new start
        err_on = 1'b1;
        go(0, 2);
        run(0, 200);
        err_on = 1'b0;
        chk("dbg_wr_cnt", 64'(wr_cnt), 64'd32);
        chk("dbg_beat_cnt", 64'(beat_cnt[0]), 64'(EXP_BEATS));
        chk("dbg_err_cnt", 64'(err_cnt[0]), 64'(EXP_ERRS));
        go(0, 0);
        run(0, 20);
        chk("dbg_beat_keep", 64'(beat_cnt[0]), 64'(EXP_BEATS));
        chk("dbg_err_keep", 64'(err_cnt[0]), 64'(EXP_ERRS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
